debounce_scan_arbiter: RTL and testbench

Multi-channel debounce controller that owns one shared sample-tick prescaler and one time-multiplexed stability-check engine. It serves N_CH noisy button inputs from a per-channel counter array. It produces per-channel debounced levels plus a single arbitrated edge-event stream (channel index and direction) with a valid/ready handshake. It sits between raw board inputs and the control FSMs that consume button events.

---
 rtl/debounce_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/debounce_scan_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_debounce_scan_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debounce scanner: FSM states,
// default timing constants and the round-robin winner search.
package debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int DEFAULT_TICK_DIV     = 500_000;
  localparam int DEFAULT_STABLE_TICKS = 4;
  localparam int MAX_CH               = 16;

  // Returns {found, index}: first set bit of req searching upward from last+1,
  // wrapping from n_ch-1 back to 0. Only the low n_ch bits of req are looked at.
  function automatic logic [4:0] rr_pick(
    input logic [MAX_CH-1:0] req,
    input logic [3:0]        last,
    input int                n_ch
  );
    logic [4:0] res;
    logic [3:0] cand;
    res = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      cand = 4'((int'(last) + k) % n_ch);
      if ((k <= n_ch) && !res[4] && req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker over the pending-event bits; the caller
// owns last_grant and updates it whenever a grant is actually taken.
module rr_arbiter
  import debounce_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_last_grant,
  output logic [CH_W-1:0] o_grant,
  output logic            o_any_req
);

  logic [MAX_CH-1:0] w_req;
  logic [4:0]        w_pick;

  always_comb begin
    w_req            = '0;
    w_req[N_CH-1:0]  = i_req;
  end

  assign w_pick    = rr_pick(w_req, 4'(i_last_grant), N_CH);
  assign o_grant   = CH_W'(w_pick[3:0]);
  assign o_any_req = w_pick[4];

endmodule

// File: rtl/debounce_scan_arbiter.sv
// N-channel button debouncer: one shared tick prescaler, one time-multiplexed
// stability checker, and a round-robin arbitrated edge-event output register.
module debounce_scan_arbiter
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  localparam int CH_W        = $clog2(N_CH),
  localparam int CNT_W       = $clog2(STABLE_TICKS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic            evt_overrun,
  output logic            busy
);

  localparam int PW = $clog2(TICK_DIV);

  if (TICK_DIV <= N_CH + 1) begin : g_bad_tick_div
    $error("TICK_DIV must be greater than N_CH+1 so a scan finishes before the next tick");
  end
  if ((N_CH < 2) || (N_CH > MAX_CH)) begin : g_bad_n_ch
    $error("N_CH must be in the range 2..16");
  end
  if (STABLE_TICKS < 2) begin : g_bad_stable
    $error("STABLE_TICKS must be at least 2");
  end

  logic [N_CH-1:0]  r_sync1;
  logic [N_CH-1:0]  r_sync2;
  logic [N_CH-1:0]  r_debounced;
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  r_dir;
  logic [CNT_W-1:0] r_cnt [N_CH];
  logic [PW-1:0]    r_presc;

  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [CH_W-1:0]  r_idx;
  logic [CH_W-1:0]  w_idx_nxt;

  logic             r_evt_valid;
  logic             r_evt_rise;
  logic [CH_W-1:0]  r_evt_ch;
  logic [CH_W-1:0]  r_last_grant;
  logic             r_overrun;

  logic             w_tick;
  logic             w_busy;
  logic             w_scan_diff;
  logic             w_cnt_done;
  logic             w_set;
  logic             w_load;
  logic             w_load_hit;
  logic             w_any_req;
  logic [CH_W-1:0]  w_grant;

  // Two-flop synchronizer per channel; raw inputs are asynchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= noisy;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // One tick launches a sweep that visits channel 0..N_CH-1, one per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_nxt = SCAN;
          w_idx_nxt   = '0;
        end
      end
      SCAN: begin
        w_busy = 1'b1;
        if (r_idx == CH_W'(N_CH - 1)) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + CH_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_scan_diff = w_busy && (r_sync2[r_idx] != r_debounced[r_idx]);
  assign w_cnt_done  = (r_cnt[r_idx] == CNT_W'(STABLE_TICKS - 1));
  assign w_set       = w_scan_diff && w_cnt_done;

  // Any scan that sees the old level again restarts the count from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_debounced <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_busy) begin
      if (!w_scan_diff) begin
        r_cnt[r_idx] <= '0;
      end else if (w_cnt_done) begin
        r_debounced[r_idx] <= r_sync2[r_idx];
        r_cnt[r_idx]       <= '0;
      end else begin
        r_cnt[r_idx] <= r_cnt[r_idx] + CNT_W'(1);
      end
    end
  end

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_arbiter (
    .i_req        (r_pend),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any_req    (w_any_req)
  );

  // Handshake: an event transfers on a cycle where evt_valid && evt_ready; while
  // evt_valid && !evt_ready the register holds evt_ch/evt_rise unchanged, and the
  // register refills on every empty or accepting cycle (one event per cycle max).
  assign w_load     = !r_evt_valid || evt_ready;
  assign w_load_hit = w_load && w_any_req && (w_grant == r_idx);

  // A new flip on a channel that is being loaded this very cycle is not an
  // overrun: the old direction leaves, the new one stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend       <= '0;
      r_dir        <= '0;
      r_overrun    <= 1'b0;
      r_evt_valid  <= 1'b0;
      r_evt_ch     <= '0;
      r_evt_rise   <= 1'b0;
      r_last_grant <= CH_W'(N_CH - 1);
    end else begin
      if (w_load && w_any_req) begin
        r_pend[w_grant] <= 1'b0;
      end
      if (w_set) begin
        r_pend[r_idx] <= 1'b1;
        r_dir[r_idx]  <= r_sync2[r_idx];
      end
      if (w_set && r_pend[r_idx] && !w_load_hit) begin
        r_overrun <= 1'b1;
      end
      if (w_load) begin
        r_evt_valid <= w_any_req;
        if (w_any_req) begin
          r_evt_ch     <= w_grant;
          r_evt_rise   <= r_dir[w_grant];
          r_last_grant <= w_grant;
        end
      end
    end
  end

  assign debounced   = r_debounced;
  assign evt_valid   = r_evt_valid;
  assign evt_ch      = r_evt_ch;
  assign evt_rise    = r_evt_rise;
  assign evt_overrun = r_overrun;
  assign busy        = w_busy;

endmodule

// File: tb/tb_debounce_scan_arbiter.sv
// Directed bench for debounce_scan_arbiter (N_CH=4, TICK_DIV=10, STABLE_TICKS=4)
// with an expected-event queue drained by an accept monitor.
module tb_debounce_scan_arbiter;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int EW   = CH_W + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] noisy;
  logic [N_CH-1:0] debounced;
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;
  logic            evt_overrun;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_ev;

  debounce_scan_arbiter #(
    .N_CH         (4),
    .TICK_DIV     (10),
    .STABLE_TICKS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .noisy       (noisy),
    .debounced   (debounced),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ch      (evt_ch),
    .evt_rise    (evt_rise),
    .evt_overrun (evt_overrun),
    .busy        (busy)
  );

  // clock / reset-relative edge counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= reset ? 0 : cyc + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to #1 after the n-th clock edge since reset release
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_flip(input string tag, input int ch, input logic lvl, input int fe);
    goto(fe - 1);
    chk({tag, "_before"}, debounced[ch], !lvl);
    goto(fe);
    chk({tag, "_after"}, debounced[ch], lvl);
    chk({tag, "_valid_lat0"}, evt_valid, 0);
    goto(fe + 1);
    chk({tag, "_valid_lat1"}, evt_valid, 1);
    chk({tag, "_ch"}, evt_ch, ch);
    chk({tag, "_rise"}, evt_rise, lvl);
  endtask

  // scoreboard: every accepted event must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL evt_extra: observed ch=%0d rise=%0d expected no event", evt_ch, evt_rise);
      end
      if (exp_q.size() > 0) begin
        exp_ev = exp_q.pop_front();
        chk("evt_stream", {evt_ch, evt_rise}, exp_ev);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    noisy     = 4'hF;
    evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_debounced", debounced, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_overrun", evt_overrun, 0);
    chk("rst_busy", busy, 0);
    noisy = 4'h4;
    reset = 1'b0;

    // 1: steady ch2 high -> one rise event after the 4th scan
    exp_q.push_back({2'd2, 1'b1});
    check_flip("t1", 2, 1'b1, 43);
    goto(46);
    chk("t1_drain", exp_q.size(), 0);

    // 2: ch0 bouncing every 7 clk never holds for 4 scans
    goto(50);
    for (int i = 0; i < 9; i++) begin
      noisy[0] = ~noisy[0];
      goto(cyc + 7);
      chk("t2_hold", debounced[0], 0);
    end
    noisy[0] = 1'b0;
    goto(160);
    chk("t2_levels", debounced, 4'h4);
    chk("t2_no_event", evt_valid, 0);

    // 3: ch1 press for 100 clk then release
    goto(163);
    noisy[1] = 1'b1;
    exp_q.push_back({2'd1, 1'b1});
    check_flip("t3_rise", 1, 1'b1, 202);
    goto(263);
    noisy[1] = 1'b0;
    exp_q.push_back({2'd1, 1'b0});
    check_flip("t3_fall", 1, 1'b0, 302);

    // 4: ch0, ch1, ch3 flip in one window while the consumer stalls
    goto(313);
    evt_ready = 1'b0;
    noisy     = 4'hF;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd3, 1'b1});
    goto(350);
    chk("t4_pre", debounced, 4'h4);
    goto(351);
    chk("t4_ch0_flip", debounced, 4'h5);
    chk("t4_empty", evt_valid, 0);
    goto(352);
    chk("t4_ch1_flip", debounced, 4'h7);
    chk("t4_head", {evt_valid, evt_ch, evt_rise}, 4'h9);
    goto(354);
    chk("t4_ch3_flip", debounced, 4'hF);
    for (int c = 355; c <= 360; c++) begin
      goto(c);
      chk("t4_stall_hold", {evt_valid, evt_ch, evt_rise}, 4'h9);
    end
    evt_ready = 1'b1;
    goto(361);
    chk("t4_second", {evt_valid, evt_ch}, 3'b101);
    goto(362);
    chk("t4_third", {evt_valid, evt_ch}, 3'b111);
    goto(363);
    chk("t4_drained", evt_valid, 0);
    chk("t4_q", exp_q.size(), 0);

    // 5: ch2 released first so it can be pressed and released under a stall
    goto(373);
    noisy[2] = 1'b0;
    exp_q.push_back({2'd2, 1'b0});
    check_flip("t5_prep", 2, 1'b0, 413);
    goto(423);
    evt_ready = 1'b0;
    noisy     = 4'b1110;
    exp_q.push_back({2'd0, 1'b0});
    goto(462);
    chk("t5_head", {evt_valid, evt_ch, evt_rise}, 4'h8);
    chk("t5_no_ovr_yet", evt_overrun, 0);
    goto(473);
    noisy[2] = 1'b0;
    exp_q.push_back({2'd2, 1'b0});
    goto(512);
    chk("t5_pre_levels", debounced, 4'b1110);
    chk("t5_pre_ovr", evt_overrun, 0);
    goto(513);
    chk("t5_levels", debounced, 4'b1010);
    chk("t5_overrun", evt_overrun, 1);
    chk("t5_head_kept", {evt_valid, evt_ch, evt_rise}, 4'h8);
    goto(520);
    evt_ready = 1'b1;
    goto(521);
    chk("t5_pending_dir", {evt_valid, evt_ch, evt_rise}, 4'hC);
    goto(522);
    chk("t5_drained", evt_valid, 0);
    chk("t5_sticky", evt_overrun, 1);

    // 6: reset in the middle of a sweep while an event is held
    goto(533);
    evt_ready = 1'b0;
    noisy     = 4'b1000;
    goto(573);
    chk("t6_held", {evt_valid, evt_ch, evt_rise}, 4'hA);
    goto(581);
    chk("t6_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_debounced", debounced, 0);
    chk("t6_valid", evt_valid, 0);
    chk("t6_overrun", evt_overrun, 0);
    chk("t6_busy_clr", busy, 0);
    chk("t6_evt_fields", {evt_ch, evt_rise}, 0);
    reset     = 1'b0;
    evt_ready = 1'b1;
    exp_q.push_back({2'd3, 1'b1});
    goto(9);
    chk("t6_idle_until_tick", busy, 0);
    goto(10);
    chk("t6_scan_restart", busy, 1);
    check_flip("t6_ch3", 3, 1'b1, 44);
    goto(50);
    chk("final_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
